mod4_addsub_sat: RTL and testbench

Parametrised signed/unsigned fixed-point add/subtract block for Q-format AXI-stream data (default Q2.14, 16 bit). Joins two input streams beat-for-beat and selects add or subtract per beat. Saturates or wraps on overflow, flags overflow per output beat and keeps a saturating overflow event counter. Drop-in successor wherever the team's two-operand stream adders are used, with full backpressure support.

---
 rtl/mod4_pkg.sv | 49 ++++
 rtl/mod4_stream_join.sv | 30 +++
 rtl/mod4_addsub_sat.sv | 203 ++++++++++++++++++++
 tb/tb_mod4_addsub_sat.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mod4_pkg
//  Purpose  : Shared definitions for the mod4 add/subtract stream block.
//             - Operation select encodings (OP_ADD / OP_SUB)
//             - Operand interpretation encodings (MODE_UNSIGNED / MODE_SIGNED)
//             - sat_limits(): max/min clamp patterns for a given width/mode
//  Revision : 1.0 - initial release
// ============================================================================
package mod4_pkg;

    // Widest result the clamp helper can describe. DATA_W must not exceed it.
    localparam int SAT_LIM_W = 64;

    // op_sub encodings
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // sign encodings
    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Clamp values, right-aligned in SAT_LIM_W bits. Callers slice the low
    // DATA_W bits.
    typedef struct packed {
        logic [SAT_LIM_W-1:0] max_v;
        logic [SAT_LIM_W-1:0] min_v;
    } sat_lim_t;

    // Signed: max = 0111..1, min = 1000..0 (two's complement bit patterns).
    // Unsigned: max = 11..1, min = 0.
    function automatic sat_lim_t sat_limits(input int width, input logic is_signed);
        sat_lim_t             lim;
        logic [SAT_LIM_W-1:0] ones;
        logic [SAT_LIM_W-1:0] one;
        ones = '1;
        one  = {{(SAT_LIM_W-1){1'b0}}, 1'b1};
        if (is_signed == MODE_SIGNED) begin
            lim.max_v = ones >> (SAT_LIM_W - width + 1);
            lim.min_v = one << (width - 1);
        end else begin
            lim.max_v = ones >> (SAT_LIM_W - width);
            lim.min_v = '0;
        end
        return lim;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod4_stream_join.sv
`default_nettype none
// ============================================================================
//  Module   : mod4_stream_join
//  Purpose  : Two-input valid/ready join. A beat is taken only when both
//             inputs are valid and the consumer can accept, so the two
//             operands always transfer in the same cycle and a lone valid
//             operand is never consumed.
//  Ports    : i_valid_a / i_valid_b  - upstream valids
//             i_accept               - consumer can take a beat this cycle
//             o_ready_a / o_ready_b  - paired readies back to each source
//             o_fire                 - joined handshake strobe
//  Revision : 1.0 - initial release
// ============================================================================
module mod4_stream_join (
    input  logic i_valid_a,
    input  logic i_valid_b,
    input  logic i_accept,
    output logic o_ready_a,
    output logic o_ready_b,
    output logic o_fire
);

    // Each side's ready depends on the other side's valid; this is what keeps
    // a waiting operand parked upstream until its partner shows up.
    assign o_ready_a = i_valid_b && i_accept;
    assign o_ready_b = i_valid_a && i_accept;
    assign o_fire    = i_valid_a && i_valid_b && i_accept;

endmodule
`default_nettype wire

// File: rtl/mod4_addsub_sat.sv
`default_nettype none
// ============================================================================
//  Module   : mod4_addsub_sat
//  Purpose  : Fixed-point (Q-format transparent) signed/unsigned add/subtract
//             on two joined AXI-stream inputs. Two register stages:
//               stage 1 - extend operands by one bit and add/subtract
//               stage 2 - range check, saturate or wrap, overflow flag
//             An overflow event counter counts delivered overflowed beats
//             and holds at its maximum.
//  Params   : DATA_W   - operand/result width (>= 4)
//             SATURATE - 1 clamp on overflow, 0 wrap to low DATA_W bits
//             CNT_W    - overflow counter width
//  Ports    : clk, reset_n (async assert, active low)
//             input_tdata_a/_tvalid_a/_tready_a - operand A stream
//             input_tdata_b/_tvalid_b/_tready_b - operand B stream
//             op_sub, sign  - operation and mode, sampled at the join
//             output_tdata/_tuser/_tvalid/_tready - result stream,
//                             tuser = overflow flag
//             ovf_count, ovf_clear - overflow event counter and its clear
//  Revision : 1.0 - initial release
// ============================================================================
module mod4_addsub_sat
    import mod4_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [DATA_W-1:0] input_tdata_a,
    input  logic              input_tvalid_a,
    output logic              input_tready_a,

    input  logic [DATA_W-1:0] input_tdata_b,
    input  logic              input_tvalid_b,
    output logic              input_tready_b,

    input  logic              op_sub,
    input  logic              sign,

    output logic [DATA_W-1:0] output_tdata,
    output logic              output_tuser,
    output logic              output_tvalid,
    input  logic              output_tready,

    output logic [CNT_W-1:0]  ovf_count,
    input  logic              ovf_clear
);

    // ------------------------------------------------------------------
    // Clamp constants
    // ------------------------------------------------------------------
    localparam sat_lim_t          c_sig_lim = sat_limits(DATA_W, MODE_SIGNED);
    localparam sat_lim_t          c_uns_lim = sat_limits(DATA_W, MODE_UNSIGNED);
    localparam logic [DATA_W-1:0] c_sig_max = c_sig_lim.max_v[DATA_W-1:0];
    localparam logic [DATA_W-1:0] c_sig_min = c_sig_lim.min_v[DATA_W-1:0];
    localparam logic [DATA_W-1:0] c_uns_max = c_uns_lim.max_v[DATA_W-1:0];
    localparam logic [DATA_W-1:0] c_uns_min = c_uns_lim.min_v[DATA_W-1:0];
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic [DATA_W:0]   r_s1_sum;
    logic              r_s1_sign;
    logic              r_s1_sub;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_user;

    logic [CNT_W-1:0]  r_ovf_count;

    // ------------------------------------------------------------------
    // Flow control: a stage may load when it is empty or its content is
    // leaving this cycle. output_tready reaches input_tready_* through
    // these enables combinationally, which is what gives full throughput.
    // ------------------------------------------------------------------
    logic w_s2_en;
    logic w_s1_en;
    logic w_fire;

    assign w_s2_en = !r_out_valid || output_tready;
    assign w_s1_en = !r_s1_valid  || w_s2_en;

    mod4_stream_join u_join (
        .i_valid_a (input_tvalid_a),
        .i_valid_b (input_tvalid_b),
        .i_accept  (w_s1_en),
        .o_ready_a (input_tready_a),
        .o_ready_b (input_tready_b),
        .o_fire    (w_fire)
    );

    // ------------------------------------------------------------------
    // Stage 1 datapath: one guard bit is enough to hold any sum or
    // difference of two DATA_W operands of the same signedness.
    // ------------------------------------------------------------------
    logic [DATA_W:0] w_a_ext;
    logic [DATA_W:0] w_b_ext;
    logic [DATA_W:0] w_sum;

    assign w_a_ext = (sign == MODE_SIGNED) ? {input_tdata_a[DATA_W-1], input_tdata_a}
                                           : {1'b0, input_tdata_a};
    assign w_b_ext = (sign == MODE_SIGNED) ? {input_tdata_b[DATA_W-1], input_tdata_b}
                                           : {1'b0, input_tdata_b};
    assign w_sum   = (op_sub == OP_SUB) ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_sub   <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= w_fire;
            if (w_fire) begin
                r_s1_sum  <= w_sum;
                r_s1_sign <= sign;
                r_s1_sub  <= op_sub;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 range check.
    // Signed: the guard bit disagreeing with the result MSB means the true
    //   value does not fit; the guard bit is the true sign, so it picks the
    //   clamp direction.
    // Unsigned: the guard bit is the carry on add and the borrow on
    //   subtract, so the clamp direction comes from the operation.
    // ------------------------------------------------------------------
    logic              w_ovf;
    logic [DATA_W-1:0] w_clamp;
    logic [DATA_W-1:0] w_result;

    always_comb begin
        w_ovf   = 1'b0;
        w_clamp = '0;
        if (r_s1_sign == MODE_SIGNED) begin
            w_ovf   = r_s1_sum[DATA_W] ^ r_s1_sum[DATA_W-1];
            w_clamp = r_s1_sum[DATA_W] ? c_sig_min : c_sig_max;
        end else begin
            w_ovf   = r_s1_sum[DATA_W];
            w_clamp = (r_s1_sub == OP_SUB) ? c_uns_min : c_uns_max;
        end
    end

    generate
        if (SATURATE) begin : g_saturate
            assign w_result = w_ovf ? w_clamp : r_s1_sum[DATA_W-1:0];
        end else begin : g_wrap
            assign w_result = r_s1_sum[DATA_W-1:0];
        end
    endgenerate

    // Output register: only loads when it is empty or being drained, so
    // data and flag stay frozen under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_user  <= 1'b0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_result;
                r_out_user <= w_ovf;
            end
        end
    end

    assign output_tvalid = r_out_valid;
    assign output_tdata  = r_out_data;
    assign output_tuser  = r_out_user;

    // ------------------------------------------------------------------
    // Overflow event counter: counts delivered flagged beats, sticks at
    // all-ones. A clear coinciding with a counted beat restarts at one so
    // that beat is not lost.
    // ------------------------------------------------------------------
    logic w_ovf_evt;

    assign w_ovf_evt = r_out_valid && output_tready && r_out_user;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_count <= '0;
        end else if (ovf_clear) begin
            r_ovf_count <= w_ovf_evt ? c_cnt_one : '0;
        end else if (w_ovf_evt && (r_ovf_count != c_cnt_max)) begin
            r_ovf_count <= r_ovf_count + c_cnt_one;
        end
    end

    assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_mod4_addsub_sat.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod4_addsub_sat
//  Purpose  : Self-checking bench for mod4_addsub_sat. Three instances share
//             one stimulus: default build, wrapping build (SATURATE = 0) and
//             a 2-bit counter build (CNT_W = 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mod4_addsub_sat;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] input_tdata_a, input_tdata_b;
    logic        input_tvalid_a, input_tvalid_b;
    logic        op_sub, sign;
    logic        output_tready;
    logic        ovf_clear;

    logic        input_tready_a, input_tready_b;
    logic [15:0] output_tdata;
    logic        output_tuser, output_tvalid;
    logic [15:0] ovf_count;

    logic        rdy_a_w, rdy_b_w, user_w, valid_w;
    logic [15:0] data_w, ovf_count_w;

    logic        rdy_a_c, rdy_b_c, user_c, valid_c;
    logic [15:0] data_c;
    logic [1:0]  ovf_count_c;

    always #5 clk = ~clk;

    mod4_addsub_sat u_dut (
        .clk(clk), .reset_n(reset_n),
        .input_tdata_a(input_tdata_a), .input_tvalid_a(input_tvalid_a), .input_tready_a(input_tready_a),
        .input_tdata_b(input_tdata_b), .input_tvalid_b(input_tvalid_b), .input_tready_b(input_tready_b),
        .op_sub(op_sub), .sign(sign),
        .output_tdata(output_tdata), .output_tuser(output_tuser), .output_tvalid(output_tvalid),
        .output_tready(output_tready), .ovf_count(ovf_count), .ovf_clear(ovf_clear)
    );

    mod4_addsub_sat #(.DATA_W(16), .SATURATE(1'b0), .CNT_W(16)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .input_tdata_a(input_tdata_a), .input_tvalid_a(input_tvalid_a), .input_tready_a(rdy_a_w),
        .input_tdata_b(input_tdata_b), .input_tvalid_b(input_tvalid_b), .input_tready_b(rdy_b_w),
        .op_sub(op_sub), .sign(sign),
        .output_tdata(data_w), .output_tuser(user_w), .output_tvalid(valid_w),
        .output_tready(output_tready), .ovf_count(ovf_count_w), .ovf_clear(ovf_clear)
    );

    mod4_addsub_sat #(.DATA_W(16), .SATURATE(1'b1), .CNT_W(2)) u_dut_c2 (
        .clk(clk), .reset_n(reset_n),
        .input_tdata_a(input_tdata_a), .input_tvalid_a(input_tvalid_a), .input_tready_a(rdy_a_c),
        .input_tdata_b(input_tdata_b), .input_tvalid_b(input_tvalid_b), .input_tready_b(rdy_b_c),
        .op_sub(op_sub), .sign(sign),
        .output_tdata(data_c), .output_tuser(user_c), .output_tvalid(valid_c),
        .output_tready(output_tready), .ovf_count(ovf_count_c), .ovf_clear(ovf_clear)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: true mathematical result, then range test.
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] d_sat;
        logic [15:0] d_wrap;
        bit          ovf;
    } exp_t;

    function automatic exp_t ref_calc(input logic [15:0] a, input logic [15:0] b,
                                      input bit sub, input bit sgn);
        exp_t   e;
        longint av, bv, r, lo, hi;
        if (sgn) begin
            av = longint'($signed(a)); bv = longint'($signed(b));
            lo = -32768; hi = 32767;
        end else begin
            av = longint'(a); bv = longint'(b);
            lo = 0; hi = 65535;
        end
        r        = sub ? av - bv : av + bv;
        e.ovf    = (r < lo) || (r > hi);
        e.d_wrap = r[15:0];
        if (r > hi)      e.d_sat = hi[15:0];
        else if (r < lo) e.d_sat = lo[15:0];
        else             e.d_sat = r[15:0];
        return e;
    endfunction

    exp_t sb[$];
    int   cnt_main = 0, cnt_wrap = 0, cnt_c2 = 0;
    int   out_count = 0;
    bit   mon_en = 1'b0;

    // ------------------------------------------------------------------
    // Monitor: mid-cycle, sees exactly the handshakes of the next edge.
    // ------------------------------------------------------------------
    initial begin : monitor
        bit          stall_prev;
        logic [15:0] hold_d;
        logic        hold_u;
        bit          evt;
        exp_t        e;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall_prev = 1'b0;
            end else begin
                chk("ovf_count", 32'(ovf_count), 32'(cnt_main));
                chk("ovf_count_wrap", 32'(ovf_count_w), 32'(cnt_wrap));
                chk("ovf_count_c2", 32'(ovf_count_c), 32'(cnt_c2));
                if (stall_prev) begin
                    chk("hold_data", 32'(output_tdata), 32'(hold_d));
                    chk("hold_user", 32'(output_tuser), 32'(hold_u));
                end
                stall_prev = output_tvalid && !output_tready;
                hold_d     = output_tdata;
                hold_u     = output_tuser;
                evt        = 1'b0;
                if (output_tvalid && output_tready) begin
                    out_count++;
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("data_sat", 32'(output_tdata), 32'(e.d_sat));
                        chk("user_sat", 32'(output_tuser), 32'(e.ovf));
                        chk("data_wrap", 32'(data_w), 32'(e.d_wrap));
                        chk("user_wrap", 32'(user_w), 32'(e.ovf));
                        chk("data_c2", 32'(data_c), 32'(e.d_sat));
                        evt = e.ovf;
                    end
                end
                if (ovf_clear) begin
                    cnt_main = evt ? 1 : 0;
                    cnt_wrap = evt ? 1 : 0;
                    cnt_c2   = evt ? 1 : 0;
                end else if (evt) begin
                    cnt_main = (cnt_main + 1 > 65535) ? 65535 : cnt_main + 1;
                    cnt_wrap = (cnt_wrap + 1 > 65535) ? 65535 : cnt_wrap + 1;
                    cnt_c2   = (cnt_c2 + 1 > 3) ? 3 : cnt_c2 + 1;
                end
                if (input_tvalid_a && input_tready_a)
                    sb.push_back(ref_calc(input_tdata_a, input_tdata_b, op_sub, sign));
            end
        end
    end

    // ------------------------------------------------------------------
    // Single-beat helper: returns the delivered result and the number of
    // cycles from join edge to output_tvalid.
    // ------------------------------------------------------------------
    task automatic send_one(input logic [15:0] a, input logic [15:0] b, input bit sub,
                            input bit sgn, output logic [15:0] d, output logic u,
                            output logic [15:0] dw, output int lat);
        int guard;
        input_tdata_a = a; input_tdata_b = b; op_sub = sub; sign = sgn;
        input_tvalid_a = 1'b1; input_tvalid_b = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!input_tready_a && guard < 20) begin @(negedge clk); guard++; end
        chk("join_timeout", 32'(guard < 20), 32'd1);
        @(posedge clk); #1;
        input_tvalid_a = 1'b0; input_tvalid_b = 1'b0;
        lat = 0;
        while (!output_tvalid && lat < 20) begin @(negedge clk); lat++; end
        d = output_tdata; u = output_tuser; dw = data_w;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [15:0] a, b;
        bit          sub, sgn;
        logic [15:0] exp_d, exp_dw;
        bit          exp_u;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [15:0] d, dw;
        logic        u;
        int          lat, idx, guard, base;
        bit          a_took, b_took;

        vecs[0] = '{16'h3000, 16'h2000, 1'b0, 1'b1, 16'h5000, 16'h5000, 1'b0};
        vecs[1] = '{16'h6000, 16'h3000, 1'b0, 1'b1, 16'h7FFF, 16'h9000, 1'b1};
        vecs[2] = '{16'h8000, 16'hC000, 1'b0, 1'b1, 16'h8000, 16'h4000, 1'b1};
        vecs[3] = '{16'h1000, 16'h3000, 1'b1, 1'b1, 16'hE000, 16'hE000, 1'b0};
        vecs[4] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h8000, 1'b0};
        vecs[7] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 16'h7FFF, 1'b1};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};

        reset_n = 1'b0; input_tvalid_a = 1'b0; input_tvalid_b = 1'b0;
        input_tdata_a = '0; input_tdata_b = '0; op_sub = 1'b0; sign = 1'b0;
        output_tready = 1'b1; ovf_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(output_tvalid), 32'd0);
        chk("rst_tdata", 32'(output_tdata), 32'd0);
        chk("rst_tuser", 32'(output_tuser), 32'd0);
        chk("rst_count", 32'(ovf_count), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // ---- directed vectors -------------------------------------------
        for (int i = 0; i < 9; i++) begin
            send_one(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sgn, d, u, dw, lat);
            chk("vec_latency", 32'(lat), 32'd2);
            chk("vec_data", 32'(d), 32'(vecs[i].exp_d));
            chk("vec_user", 32'(u), 32'(vecs[i].exp_u));
            chk("vec_wrap", 32'(dw), 32'(vecs[i].exp_dw));
            if (i == 2) chk("count_after_two", 32'(ovf_count), 32'd2);
        end
        chk("count_total", 32'(ovf_count), 32'd5);
        chk("count_c2_sat", 32'(ovf_count_c), 32'd3);

        // ---- skew: A waits three cycles for B ---------------------------
        base = out_count;
        input_tdata_a = 16'h0100; input_tdata_b = 16'h0200; op_sub = 1'b0; sign = 1'b1;
        input_tvalid_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("skew_ready_a", 32'(input_tready_a), 32'd0);
            @(posedge clk); #1;
        end
        chk("skew_no_early", 32'(out_count - base), 32'd0);
        send_one(16'h0100, 16'h0200, 1'b0, 1'b1, d, u, dw, lat);
        chk("skew_data", 32'(d), 32'h0300);
        @(negedge clk);
        chk("skew_one_beat", 32'(out_count - base), 32'd1);
        @(posedge clk); #1;

        // ---- backpressure: 6 stalled cycles while streaming 5 beats -----
        base = out_count; idx = 0; output_tready = 1'b0; op_sub = 1'b0; sign = 1'b1;
        for (int c = 0; c < 6; c++) begin
            input_tvalid_a = 1'b1; input_tvalid_b = 1'b1;
            input_tdata_a = 16'(idx * 16'h0100); input_tdata_b = 16'h0010;
            @(negedge clk);
            if (input_tvalid_a && input_tready_a) idx++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_ready_a", 32'(input_tready_a), 32'd0);
        chk("bp_ready_b", 32'(input_tready_b), 32'd0);
        @(posedge clk); #1;
        output_tready = 1'b1; guard = 0;
        while (idx < 5 && guard < 30) begin
            input_tdata_a = 16'(idx * 16'h0100); input_tdata_b = 16'h0010;
            @(negedge clk);
            if (input_tvalid_a && input_tready_a) idx++;
            @(posedge clk); #1;
            guard++;
        end
        input_tvalid_a = 1'b0; input_tvalid_b = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 30) begin @(posedge clk); #1; guard++; end
        chk("bp_drained", 32'(sb.size()), 32'd0);
        chk("bp_out_count", 32'(out_count - base), 32'd5);

        // ---- clear coinciding with an overflowed handshake --------------
        input_tdata_a = 16'h6000; input_tdata_b = 16'h3000; op_sub = 1'b0; sign = 1'b1;
        input_tvalid_a = 1'b1; input_tvalid_b = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        input_tvalid_a = 1'b0; input_tvalid_b = 1'b0;
        @(posedge clk); #1;
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        chk("clear_with_ovf", 32'(ovf_count), 32'd1);
        chk("clear_with_ovf_c2", 32'(ovf_count_c), 32'd1);
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        chk("clear_alone", 32'(ovf_count), 32'd0);

        // ---- reset mid-stream -------------------------------------------
        input_tvalid_a = 1'b1; input_tvalid_b = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        mon_en = 1'b0;
        reset_n = 1'b0;
        input_tvalid_a = 1'b0; input_tvalid_b = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(output_tvalid), 32'd0);
        chk("midrst_count", 32'(ovf_count), 32'd0);
        chk("midrst_count_c2", 32'(ovf_count_c), 32'd0);
        sb.delete(); cnt_main = 0; cnt_wrap = 0; cnt_c2 = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_beat", 32'(output_tvalid), 32'd0);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;

        // ---- randomized traffic against the reference model -------------
        a_took = 1'b1; b_took = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (!input_tvalid_a || a_took) begin
                input_tvalid_a = ($urandom_range(0, 3) != 0);
                input_tdata_a  = ($urandom_range(0, 3) == 0) ? 16'h8000 ^ 16'($urandom_range(0, 1)) : 16'($urandom);
            end
            if (!input_tvalid_b || b_took) begin
                input_tvalid_b = ($urandom_range(0, 3) != 0);
                input_tdata_b  = ($urandom_range(0, 3) == 0) ? 16'h7FFF + 16'($urandom_range(0, 1)) : 16'($urandom);
            end
            op_sub        = 1'($urandom);
            sign          = 1'($urandom);
            output_tready = ($urandom_range(0, 3) != 0);
            ovf_clear     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            a_took = input_tvalid_a && input_tready_a;
            b_took = input_tvalid_b && input_tready_b;
            @(posedge clk); #1;
        end
        input_tvalid_a = 1'b0; input_tvalid_b = 1'b0;
        output_tready = 1'b1; ovf_clear = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("rand_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
